// File: rtl/a2d_pkg.sv
// a2d_pkg
// Shared types, default channel map and command-word helper for the A2D channel
// scheduler. The ADC128S takes its channel select in bits [13:11] of the 16-bit
// SPI command word; the data clocked out in a transaction belongs to the channel
// selected in the previous one. That is why each conversion is two transactions.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, SEL, WT1, GAP, RD, WT2, UPD} state_t;

  typedef enum logic [1:0] {LFT, RGHT, BATT} scan_t;

  // Which requester owns the conversion in flight (also used as last-served).
  typedef enum logic {SRC_SCAN, SRC_OD} src_t;

  localparam logic [2:0] LFT_CH_DEF  = 3'd0;
  localparam logic [2:0] RGHT_CH_DEF = 3'd4;
  localparam logic [2:0] BATT_CH_DEF = 3'd5;
  localparam int         GAP_CYC_DEF = 4;

  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  function automatic scan_t next_scan(input scan_t s);
    case (s)
      LFT:     return RGHT;
      RGHT:    return BATT;
      default: return LFT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_chan_sched.sv
// a2d_chan_sched
// Shares the ADC128S (through the SPI monitor) between the periodic
// left/right load-cell + battery scan (paced by nxt) and an on-demand
// single-channel read port. Each conversion: SEL transaction (channel select),
// SS_n-high gap, RD transaction (same command, returns the conversion).
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   nxt                1-clk pulse: do the next scan conversion
//   req_vld/req_chnl   on-demand request (held until req_rdy) and its channel
//   req_rdy            1-clk accept of the on-demand request
//   rsp_vld/rsp_data   on-demand result pulse and value
//   wrt/cmd            start pulse and command word to the SPI monitor
//   done/rd_data       transaction complete pulse and read data from the monitor
//   lft_ld/rght_ld/batt latest scan results; scan_vld pulses when one updates
//   ovr                sticky: nxt arrived while a scan request was already pending
module a2d_chan_sched
  import a2d_pkg::*;
#(
  parameter logic [2:0] LFT_CH  = LFT_CH_DEF,
  parameter logic [2:0] RGHT_CH = RGHT_CH_DEF,
  parameter logic [2:0] BATT_CH = BATT_CH_DEF,
  parameter int         GAP_CYC = GAP_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        req_vld,
  input  logic [2:0]  req_chnl,
  output logic        req_rdy,
  output logic        rsp_vld,
  output logic [11:0] rsp_data,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        scan_vld,
  output logic        ovr
);

  localparam int            CW       = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  state_t        state;
  scan_t         ptr;
  src_t          src;
  src_t          last_src;
  logic          nxt_pend;
  logic [CW-1:0] gap_cnt;
  logic [11:0]   res_q;
  logic [2:0]    scan_ch;
  logic          scan_req;
  logic          scan_gnt;
  logic          od_gnt;

  // Upper nibble of the SPI word carries no conversion data.
  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_data[15:12];

  always_comb begin
    case (ptr)
      LFT:     scan_ch = LFT_CH;
      RGHT:    scan_ch = RGHT_CH;
      default: scan_ch = BATT_CH;
    endcase
  end

  // A nxt arriving in the IDLE clock is granted directly, so a simultaneous
  // on-demand request loses to it when the on-demand side was served last.
  assign scan_req = nxt_pend | nxt;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    scan_gnt = 1'b0;
    od_gnt   = 1'b0;
    if (state == IDLE && !rst) begin
      if (scan_req && req_vld) begin
        if (last_src == SRC_OD) scan_gnt = 1'b1;
        else                    od_gnt   = 1'b1;
      end else if (scan_req) begin
        scan_gnt = 1'b1;
      end else if (req_vld) begin
        od_gnt = 1'b1;
      end
    end
  end

  // Accept is combinational so the requester sees it in the clock the grant
  // is taken; the handshake completes on the IDLE->SEL edge.
  assign req_rdy = od_gnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= LFT;
      src      <= SRC_SCAN;
      last_src <= SRC_OD;
      nxt_pend <= 1'b0;
      gap_cnt  <= '0;
      res_q    <= '0;
      wrt      <= 1'b0;
      cmd      <= '0;
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
      lft_ld   <= '0;
      rght_ld  <= '0;
      batt     <= '0;
      scan_vld <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      wrt      <= 1'b0;
      rsp_vld  <= 1'b0;
      scan_vld <= 1'b0;

      // A second nxt before the first is consumed is dropped and flagged.
      if (nxt && nxt_pend) ovr <= 1'b1;
      if (scan_gnt)        nxt_pend <= 1'b0;
      else if (nxt)        nxt_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (scan_gnt) begin
            state    <= SEL;
            wrt      <= 1'b1;
            cmd      <= mk_cmd(scan_ch);
            src      <= SRC_SCAN;
            last_src <= SRC_SCAN;
          end else if (od_gnt) begin
            // cmd holds the on-demand channel for the whole conversion.
            state    <= SEL;
            wrt      <= 1'b1;
            cmd      <= mk_cmd(req_chnl);
            src      <= SRC_OD;
            last_src <= SRC_OD;
          end
        end
        SEL: state <= WT1;
        WT1: begin
          if (done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          // Holds SS_n high for GAP_CYC clocks before the data transaction.
          if (gap_cnt == GAP_LAST) begin
            state <= RD;
            wrt   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + CW'(1);
          end
        end
        RD: state <= WT2;
        WT2: begin
          if (done) begin
            res_q <= rd_data[11:0];
            state <= UPD;
          end
        end
        UPD: begin
          if (src == SRC_SCAN) begin
            case (ptr)
              LFT:     lft_ld  <= res_q;
              RGHT:    rght_ld <= res_q;
              default: batt    <= res_q;
            endcase
            scan_vld <= 1'b1;
            ptr      <= next_scan(ptr);
          end else begin
            rsp_data <= res_q;
            rsp_vld  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_chan_sched.sv
// tb_a2d_chan_sched
// Directed bench: behavioural ADC128S + SPI monitor (fixed transaction latency,
// returns the channel selected in the previous transaction) around the scheduler.
module tb_a2d_chan_sched;

  localparam int LAT = 20;

  logic        clk;
  logic        rst;
  logic        nxt;
  logic        req_vld;
  logic [2:0]  req_chnl;
  logic        req_rdy;
  logic        rsp_vld;
  logic [11:0] rsp_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        scan_vld;
  logic        ovr;

  int n_checks = 0;
  int n_errors = 0;

  a2d_chan_sched dut (
    .clk      (clk),
    .rst      (rst),
    .nxt      (nxt),
    .req_vld  (req_vld),
    .req_chnl (req_chnl),
    .req_rdy  (req_rdy),
    .rsp_vld  (rsp_vld),
    .rsp_data (rsp_data),
    .wrt      (wrt),
    .cmd      (cmd),
    .done     (done),
    .rd_data  (rd_data),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .batt     (batt),
    .scan_vld (scan_vld),
    .ovr      (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- ADC128S + SPI monitor model ----------------
  logic [11:0] adc [8];
  logic        mdl_busy;
  logic        mdl_done;
  logic        spur_done;
  int          mdl_cnt;
  logic [15:0] cur_cmd;
  logic [2:0]  prev_ch;

  assign done = mdl_done | spur_done;

  always @(negedge clk) begin
    if (rst) begin
      mdl_busy = 1'b0;
      mdl_done = 1'b0;
      mdl_cnt  = 0;
      prev_ch  = 3'd0;
      rd_data  = 16'h0000;
      cur_cmd  = 16'h0000;
    end else begin
      mdl_done = 1'b0;
      if (wrt) begin
        check("wrt_while_busy", {31'd0, mdl_busy}, 32'd0);
        mdl_busy = 1'b1;
        mdl_cnt  = LAT;
        cur_cmd  = cmd;
      end else if (mdl_busy) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          check("cmd_stable", {16'd0, cmd}, {16'd0, cur_cmd});
          mdl_done = 1'b1;
          rd_data  = {4'h0, adc[prev_ch]};
          prev_ch  = cur_cmd[13:11];
          mdl_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- event counters ----------------
  int scan_cnt = 0;
  int rsp_cnt  = 0;
  int rdy_cnt  = 0;
  int wrt_cnt  = 0;

  always begin
    @(negedge clk);
    #1;
    if (scan_vld) scan_cnt++;
    if (rsp_vld)  rsp_cnt++;
    if (req_rdy)  rdy_cnt++;
    if (wrt)      wrt_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_scan(input string tag);
    int n = 0;
    while (!scan_vld && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, {31'd0, scan_vld}, 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_vld && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, {31'd0, rsp_vld}, 32'd1);
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    #2;
    while (!req_rdy && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, {31'd0, req_rdy}, 32'd1);
  endtask

  // nxt pulse, then check SEL starts one clock after the grant with the right cmd.
  task automatic do_scan(input logic [15:0] exp_cmd, input string tag);
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    #2;
    check({tag, "_wrt"}, {31'd0, wrt}, 32'd1);
    check({tag, "_cmd"}, {16'd0, cmd}, {16'd0, exp_cmd});
    wait_scan({tag, "_done"});
  endtask

  task automatic od_read(input logic [2:0] ch, input logic [11:0] exp, input string tag);
    @(negedge clk);
    req_vld  = 1'b1;
    req_chnl = ch;
    wait_rdy({tag, "_rdy"});
    @(negedge clk);
    req_vld  = 1'b0;
    req_chnl = 3'd1;  // later changes must not affect the read in flight
    wait_rsp({tag, "_rsp"});
    check({tag, "_data"}, {20'd0, rsp_data}, {20'd0, exp});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_scan;
    int base_rdy;
    int base_wrt;
    int n;

    for (int i = 0; i < 8; i++) adc[i] = 12'h000;
    adc[0] = 12'h001;
    adc[4] = 12'h005;
    adc[5] = 12'h015;
    rst       = 1'b1;
    nxt       = 1'b0;
    req_vld   = 1'b0;
    req_chnl  = 3'd0;
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_wrt",  {31'd0, wrt}, 32'd0);
    check("rst_cmd",  {16'd0, cmd}, 32'd0);
    check("rst_regs", {lft_ld, rght_ld, batt[7:0]}, 32'd0);
    check("rst_flags", {28'd0, ovr, scan_vld, rsp_vld, req_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic scan: three conversions spaced 2000 clocks.
    do_scan(16'h0000, "s1_lft");
    check("s1_lft_val", {20'd0, lft_ld}, 32'h001);
    repeat (2000) @(negedge clk);
    do_scan(16'h2000, "s1_rght");
    check("s1_rght_val", {20'd0, rght_ld}, 32'h005);
    repeat (2000) @(negedge clk);
    do_scan(16'h2800, "s1_batt");
    check("s1_batt_val", {20'd0, batt}, 32'h015);
    repeat (20) @(negedge clk);
    check("s1_scan_cnt", scan_cnt, 32'd3);
    check("s1_ovr", {31'd0, ovr}, 32'd0);

    // New values, six scans: pointer wraps twice.
    adc[0] = 12'h018;
    adc[4] = 12'h0FF;
    adc[5] = 12'h123;
    for (int k = 0; k < 2; k++) begin
      do_scan(16'h0000, "s2_lft");
      check("s2_lft_val", {20'd0, lft_ld}, 32'h018);
      repeat (5) @(negedge clk);
      do_scan(16'h2000, "s2_rght");
      check("s2_rght_val", {20'd0, rght_ld}, 32'h0FF);
      repeat (5) @(negedge clk);
      do_scan(16'h2800, "s2_batt");
      check("s2_batt_val", {20'd0, batt}, 32'h123);
      repeat (5) @(negedge clk);
    end
    check("s2_scan_cnt", scan_cnt, 32'd9);

    // On-demand read so last-served becomes ON_DEMAND; channel equal to a scan
    // channel must leave the scan regs alone.
    base_scan = scan_cnt;
    od_read(3'd4, 12'h0FF, "od1");
    check("od1_no_scan", scan_cnt, base_scan);
    check("od1_rght_kept", {20'd0, rght_ld}, 32'h0FF);
    repeat (5) @(negedge clk);

    // Simultaneous nxt and req: scan goes first, then the on-demand read.
    base_scan = scan_cnt;
    base_rdy  = rdy_cnt;
    @(negedge clk);
    nxt      = 1'b1;
    req_vld  = 1'b1;
    req_chnl = 3'd5;
    #2;
    check("arb_no_rdy_first", {31'd0, req_rdy}, 32'd0);
    @(negedge clk);
    nxt = 1'b0;
    #2;
    check("arb_scan_cmd", {16'd0, cmd}, 32'h0000);
    wait_rdy("arb_rdy");
    check("arb_scan_before", scan_cnt, base_scan + 1);
    check("arb_lft_val", {20'd0, lft_ld}, 32'h018);
    @(negedge clk);
    req_vld  = 1'b0;
    req_chnl = 3'd0;
    wait_rsp("arb_rsp");
    check("arb_rsp_data", {20'd0, rsp_data}, 32'h123);
    repeat (5) @(negedge clk);
    check("arb_rdy_once", rdy_cnt, base_rdy + 1);
    check("arb_batt_kept", {20'd0, batt}, 32'h123);

    // Three nxt inside one conversion: one extra conversion, ovr sticky.
    adc[4] = 12'h0AA;
    adc[5] = 12'h055;
    base_scan = scan_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
      repeat (4) @(negedge clk);
    end
    #2;
    check("ovr_set", {31'd0, ovr}, 32'd1);
    repeat (400) @(negedge clk);
    #2;
    check("ovr_conv_cnt", scan_cnt, base_scan + 2);
    check("ovr_rght_val", {20'd0, rght_ld}, 32'h0AA);
    check("ovr_batt_val", {20'd0, batt}, 32'h055);
    check("ovr_sticky", {31'd0, ovr}, 32'd1);

    // Reset during WT2 of a RGHT conversion.
    do_scan(16'h0000, "r_lft");
    repeat (5) @(negedge clk);
    base_wrt = wrt_cnt;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    n = 0;
    while (wrt_cnt < base_wrt + 2 && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("r_second_wrt", wrt_cnt, base_wrt + 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("r_wrt_low", {31'd0, wrt}, 32'd0);
    check("r_regs_clr", {lft_ld, rght_ld, batt[7:0]}, 32'd0);
    check("r_ovr_clr", {31'd0, ovr}, 32'd0);
    check("r_cmd_clr", {16'd0, cmd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_scan(16'h0000, "r_resume");
    check("r_resume_lft", {20'd0, lft_ld}, 32'h018);
    check("r_resume_rght", {20'd0, rght_ld}, 32'h000);

    // Spurious done in IDLE: nothing happens, next scan still correct.
    repeat (5) @(negedge clk);
    base_wrt  = wrt_cnt;
    base_scan = scan_cnt;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("spur_no_wrt", wrt_cnt, base_wrt);
    check("spur_no_scan", scan_cnt, base_scan);
    do_scan(16'h2000, "spur_next");
    check("spur_next_val", {20'd0, rght_ld}, 32'h0AA);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
